// File: rtl/uart_pkg.sv
// Shared definitions for the UART frame receiver path feeding the Hamming(7,4) decoder.
package uart_pkg;

  // Data bits per frame: one Hamming(7,4) codeword.
  localparam int FRAME_BITS = 7;

  // Receiver FSM state encodings (visible on the debug port).
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_IDLE = 3'd4
  } rx_state_e;

  // Width of a counter that must reach clks_per_bit-1.
  function automatic int baud_cnt_width(input int clks_per_bit);
    return (clks_per_bit < 2) ? 1 : $clog2(clks_per_bit);
  endfunction

endpackage

// File: rtl/uart_rx_frame7_if.sv
// Line-side inputs and parallel word outputs of the 7-bit frame receiver.
interface uart_rx_frame7_if;
  import uart_pkg::*;

  logic                  ena;
  logic                  rx;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  frame_error;
  logic                  busy;

  // Whoever drives the serial line and consumes the received words.
  modport master (
    output ena, rx,
    input  rx_data, rx_valid, frame_error, busy
  );

  // The receiver itself.
  modport slave (
    input  ena, rx,
    output rx_data, rx_valid, frame_error, busy
  );

endinterface

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs; reset value is selectable
// so an idle-high serial line can come out of reset already idle.
module sync_2ff #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two back-to-back flops; only the second stage is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_frame7.sv
// UART receiver for 7-bit codeword frames (start, 7 data LSB-first, stop, no parity).
// Good frames produce a one-cycle rx_valid with the word on rx_data; a low stop bit
// produces a one-cycle frame_error and the line must return high before re-arming.
// CLKS_PER_BIT must be even and within 4..4095.
module uart_rx_frame7
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  uart_rx_frame7_if.slave        rx_bus,
  output logic [2:0]             debug_state_out,
  output logic [2:0]             debug_bit_idx_out
);

  localparam int CNT_W = baud_cnt_width(CLKS_PER_BIT);
  localparam int HALF  = CLKS_PER_BIT / 2;

  // Start bit is checked at its centre; data and stop bits one full bit later each.
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       LAST_IDX  = 3'(FRAME_BITS - 1);

  logic                  rx_s;
  rx_state_e             state_q;
  logic [CNT_W-1:0]      baud_cnt_q;
  logic [2:0]            bit_idx_q;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] rx_data_q;
  logic                  rx_valid_q;
  logic                  frame_error_q;

  sync_2ff #(
    .WIDTH     (1),
    .RESET_VAL (1'b1)
  ) u_rx_sync (
    .clk (clk),
    .rst (rst),
    .d_i (rx_bus.rx),
    .q_o (rx_s)
  );

  // Frame FSM: counts baud ticks, samples bit centres and registers the strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      baud_cnt_q    <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      case (state_q)
        IDLE: begin
          baud_cnt_q <= '0;
          if (rx_bus.ena && !rx_s) begin
            state_q <= START;
          end
        end

        START: begin
          if (!rx_bus.ena) begin
            state_q    <= WAIT_IDLE;
            baud_cnt_q <= '0;
          end else if (baud_cnt_q == HALF_LAST) begin
            baud_cnt_q <= '0;
            if (!rx_s) begin
              state_q   <= DATA;
              bit_idx_q <= '0;
            end else begin
              // Line went back high before the start-bit centre: a glitch.
              state_q <= IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
          end
        end

        DATA: begin
          if (!rx_bus.ena) begin
            state_q    <= WAIT_IDLE;
            baud_cnt_q <= '0;
          end else if (baud_cnt_q == BIT_LAST) begin
            baud_cnt_q         <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == LAST_IDX) begin
              state_q <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
          end
        end

        STOP: begin
          if (!rx_bus.ena) begin
            state_q    <= WAIT_IDLE;
            baud_cnt_q <= '0;
          end else if (baud_cnt_q == BIT_LAST) begin
            // Leaving at the stop-bit centre lets a back-to-back start bit be caught.
            baud_cnt_q <= '0;
            if (rx_s) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= WAIT_IDLE;
            end
          end else begin
            baud_cnt_q <= baud_cnt_q + CNT_ONE;
          end
        end

        WAIT_IDLE: begin
          // A held-low (break) line must go idle before another frame can start.
          baud_cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end

        default: begin
          state_q    <= IDLE;
          baud_cnt_q <= '0;
        end
      endcase
    end
  end

  assign rx_bus.rx_data     = rx_data_q;
  assign rx_bus.rx_valid    = rx_valid_q;
  assign rx_bus.frame_error = frame_error_q;
  assign rx_bus.busy        = (state_q != IDLE);
  assign debug_state_out    = state_q;
  assign debug_bit_idx_out  = bit_idx_q;

endmodule

// File: tb/tb_uart_rx_frame7.sv
// Self-checking bench for uart_rx_frame7 at CLKS_PER_BIT=8. A frame-level model
// predicts, for every frame sent, the cycle and kind of strobe it must produce.
module tb_uart_rx_frame7;

  localparam int CPB  = 8;
  localparam int HALF = CPB / 2;
  // Pin low at cycle k -> rx_s low from k+2 -> strobe visible at k+3+HALF+8*CPB.
  localparam int LAT  = 3 + HALF + 8 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;
  logic [2:0] dbg_idx;

  uart_rx_frame7_if bus ();

  uart_rx_frame7 #(.CLKS_PER_BIT(CPB)) dut (
    .clk               (clk),
    .rst               (rst),
    .rx_bus            (bus),
    .debug_state_out   (dbg_state),
    .debug_bit_idx_out (dbg_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp_v, exp_v, cyc);
    end
  endtask

  // Frame-level expectations: when a strobe must appear, which kind, which word.
  typedef struct {
    int         cyc;
    bit         err;
    logic [6:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_valid = 0;
  int         n_ferr  = 0;
  int         vcyc[$];
  logic [6:0] last_good = 7'h00;

  // Strobe monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        n_valid++;
        vcyc.push_back(cyc);
        chk("valid_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("valid_cycle", cyc, mon_e.cyc);
          chk("valid_kind_err", mon_e.err, 0);
          chk("valid_data", bus.rx_data, mon_e.data);
        end
        chk("valid_ferr_exclusive", bus.frame_error, 0);
      end else if (bus.frame_error) begin
        n_ferr++;
        chk("ferr_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          chk("ferr_cycle", cyc, mon_e.cyc);
          chk("ferr_kind_err", mon_e.err, 1);
        end
      end
    end
  end

  task automatic drive_bit(input logic b);
    bus.rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Send one whole frame starting at the current negedge, optionally registering
  // the strobe it should produce.
  task automatic send_frame(input logic [6:0] d, input bit stop, input int gap, input bit expect_it);
    exp_t e;
    $display("frame cyc=%0d data=0x%02h stop=%0d gap=%0d expect=%0d", cyc, d, stop, gap, expect_it);
    if (expect_it) begin
      e.cyc  = cyc + LAT;
      e.err  = !stop;
      e.data = d;
      exp_q.push_back(e);
      if (stop) last_good = d;
    end
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(stop);
    repeat (gap) drive_bit(1'b1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rx_data"}, bus.rx_data, 0);
    chk({tag, "_rx_valid"}, bus.rx_valid, 0);
    chk({tag, "_frame_error"}, bus.frame_error, 0);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_state"}, dbg_state, 0);
    chk({tag, "_bit_idx"}, dbg_idx, 0);
  endtask

  typedef struct {
    logic [6:0] data;
    bit         stop;
    int         gap;
    logic [6:0] exp_data;
    int         exp_nv;
    int         exp_nf;
  } vec_t;

  vec_t       tbl[5];
  int         v0, f0;
  logic [6:0] d0;
  logic [6:0] rd;
  bit         rstop;
  int         rgap;

  initial begin
    tbl[0] = '{7'b1010101, 1'b1, 1, 7'h55, 1, 0};
    tbl[1] = '{7'b0110011, 1'b1, 0, 7'h33, 1, 0};
    tbl[2] = '{7'b1111111, 1'b1, 2, 7'h7F, 1, 0};
    tbl[3] = '{7'h2A,      1'b0, 2, 7'h7F, 0, 1};
    tbl[4] = '{7'h12,      1'b1, 1, 7'h12, 1, 0};

    rst     = 1'b1;
    bus.ena = 1'b1;
    bus.rx  = 1'b1;
    repeat (4) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;
    repeat (2 * CPB) @(negedge clk);

    // Good frames, back-to-back pair and a bad stop bit.
    for (int i = 0; i < 5; i++) begin
      v0 = n_valid;
      f0 = n_ferr;
      send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, 1'b1);
      chk("tbl_rx_data", bus.rx_data, tbl[i].exp_data);
      chk("tbl_valid_count", n_valid - v0, tbl[i].exp_nv);
      chk("tbl_ferr_count", n_ferr - f0, tbl[i].exp_nf);
    end
    chk("b2b_pulse_count", vcyc.size(), 4);
    if (vcyc.size() >= 3) chk("b2b_spacing", vcyc[2] - vcyc[1], 9 * CPB);
    chk("idle_busy", bus.busy, 0);

    // Start-bit glitch of two cycles.
    v0 = n_valid; f0 = n_ferr; d0 = bus.rx_data;
    bus.rx = 1'b0;
    repeat (2) @(negedge clk);
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_in_start", dbg_state, 1);
    repeat (6) @(negedge clk);
    chk("glitch_back_idle", dbg_state, 0);
    repeat (2 * CPB) @(negedge clk);
    chk("glitch_no_valid", n_valid - v0, 0);
    chk("glitch_no_ferr", n_ferr - f0, 0);
    chk("glitch_rx_data", bus.rx_data, d0);

    // Bad stop bit followed by a long break.
    v0 = n_valid; f0 = n_ferr; d0 = bus.rx_data;
    send_frame(7'h2A, 1'b0, 0, 1'b1);
    bus.rx = 1'b0;
    repeat (20 * CPB) @(negedge clk);
    chk("break_wait_idle", dbg_state, 4);
    chk("break_ferr_once", n_ferr - f0, 1);
    chk("break_no_valid", n_valid - v0, 0);
    chk("break_rx_data", bus.rx_data, d0);
    bus.rx = 1'b1;
    repeat (4) @(negedge clk);
    chk("break_released", dbg_state, 0);
    repeat (CPB) @(negedge clk);

    // Reset in the middle of data bit 3.
    drive_bit(1'b0);
    drive_bit(1'b1);
    drive_bit(1'b0);
    drive_bit(1'b1);
    chk("midrst_state_data", dbg_state, 2);
    chk("midrst_bit_idx", dbg_idx, 3);
    rst    = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    chk_reset_outputs("midrst");
    rst       = 1'b0;
    last_good = 7'h00;
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(7'h01, 1'b1, 1, 1'b1);
    chk("after_rst_rx_data", bus.rx_data, 7'h01);

    // Enable dropped mid-frame, then a whole frame with enable low.
    v0 = n_valid; f0 = n_ferr;
    repeat (4) drive_bit(1'b0);
    bus.ena = 1'b0;
    @(negedge clk);
    chk("abort_wait_idle", dbg_state, 4);
    repeat (4) drive_bit(1'b0);
    chk("abort_still_wait", dbg_state, 4);
    drive_bit(1'b1);
    drive_bit(1'b1);
    chk("abort_idle", dbg_state, 0);
    send_frame(7'h5A, 1'b1, 1, 1'b0);
    chk("disabled_state", dbg_state, 0);
    chk("disabled_no_valid", n_valid - v0, 0);
    chk("disabled_no_ferr", n_ferr - f0, 0);
    chk("disabled_rx_data", bus.rx_data, last_good);
    bus.ena = 1'b1;
    drive_bit(1'b1);
    send_frame(7'h40, 1'b1, 1, 1'b1);
    chk("reenabled_rx_data", bus.rx_data, 7'h40);

    // Random frames, random stop bits and idle gaps.
    for (int i = 0; i < 30; i++) begin
      rd    = 7'($urandom_range(0, 127));
      rstop = ($urandom_range(0, 3) != 0);
      rgap  = rstop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      v0 = n_valid; f0 = n_ferr;
      send_frame(rd, rstop, rgap, 1'b1);
      chk("rand_rx_data", bus.rx_data, last_good);
      chk("rand_valid_count", n_valid - v0, rstop ? 1 : 0);
      chk("rand_ferr_count", n_ferr - f0, rstop ? 0 : 1);
    end

    repeat (3 * CPB) @(negedge clk);
    chk("expectations_drained", exp_q.size(), 0);
    chk("final_busy", bus.busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_frame7.md
Name: uart_rx_frame7

Overview:
UART serial receiver that sits directly upstream of the Hamming(7,4) decoder. It deserialises 7-bit codeword frames (1 start, 7 data LSB-first, 1 stop, no parity) from the rx pin. Each good frame is presented as a 7-bit parallel word with a one-cycle valid strobe, which drives the decoder's parallel input and enable.
- Framing errors and start-bit glitches are detected and never produce a valid strobe.

Parameters:
CLKS_PER_BIT, 16, clk cycles per UART bit; legal range 4..4095, must be even
FRAME_BITS, 7, data bits per frame; fixed at 7 for the Hamming(7,4) path

Ports:
clk  input  1  system clock; the only clock
rst  input  1  synchronous, active-high reset
ena  input  1  receive enable; no new frame is started while low
rx  input  1  asynchronous serial line; idle high
rx_data  output  7  last correctly framed word; bit 0 is the first data bit received
rx_valid  output  1  one-cycle pulse when rx_data is updated
frame_error  output  1  one-cycle pulse when the stop bit is sampled low
busy  output  1  high whenever state != IDLE
debug_state_out  output  3  current FSM state encoding
debug_bit_idx_out  output  3  current data bit index

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high, sampled only on the rising edge of clk; it has priority over everything else.
- Reset values:
  - state=IDLE; rx_data=0; rx_valid=0; frame_error=0; busy=0.
  - Synchroniser flops=1; baud_cnt=0; bit_idx=0; shift register=0.
- Synchronisation:
  - rx passes through a 2-flop synchroniser; only the synchronised output (rx_s) is used.
  - Synchroniser latency is 2 cycles.
- Counters:
  - baud_cnt is $clog2(CLKS_PER_BIT) bits wide and resets to 0 on every state change.
  - HALF = CLKS_PER_BIT/2.
- States: IDLE=0, START=1, DATA=2, STOP=3, WAIT_IDLE=4.
- IDLE: if ena=1 and rx_s=0, go to START.
- START:
  - baud_cnt increments each cycle.
  - At baud_cnt==HALF-1, sample rx_s:
    - rx_s=0: go to DATA with bit_idx=0.
    - rx_s=1: treat as a glitch; go to IDLE. No rx_valid, no frame_error.
- DATA:
  - At baud_cnt==CLKS_PER_BIT-1, write rx_s into shift[bit_idx].
  - If bit_idx==6, go to STOP; otherwise bit_idx+1.
  - Sampling points are therefore bit centres.
- STOP:
  - At baud_cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: rx_data<=shift, rx_valid=1 for exactly one cycle, go to IDLE.
  - rx_s=0: frame_error=1 for one cycle, rx_data unchanged, go to WAIT_IDLE.
- WAIT_IDLE: stay until rx_s=1, then go to IDLE. This prevents a break or low line from retriggering a frame.
- ena deasserted in START, DATA or STOP:
  - Abort to WAIT_IDLE on the next edge.
  - No rx_valid, no frame_error, rx_data unchanged.
- ena in WAIT_IDLE: has no effect.
- Latency:
  - rx_valid rises HALF + 8*CLKS_PER_BIT + 1 cycles after the first cycle in which rx_s==0 in IDLE.
  - Plus the 2-cycle synchroniser delay relative to the rx pin.
- Back-to-back frames: the next start bit may begin immediately after the stop-bit centre. IDLE is re-entered half a bit early, so frames with no extra idle time are received.
- rx_valid and frame_error are never high in the same cycle.
- rx_data is stable whenever rx_valid=0.

Decomposition:
- Package uart_pkg holds:
  - state encodings (IDLE..WAIT_IDLE, 3 bits)
  - FRAME_BITS=7
  - localparam helper for the baud counter width
- One natural sub-module: sync_2ff, a generic 2-flop synchroniser.
  - Reset value is a parameter; it is 1 here.
  - The transmitter side reuses it.

Test Plan:
1. CLKS_PER_BIT=8; send frame data 7'b1010101 with a good stop bit -> rx_valid pulses for 1 cycle, rx_data=7'h55, frame_error stays 0, busy returns to 0.
2. Send 7'b0110011 (Hamming codeword for data 4'b0110) then 7'b1111111 back-to-back with zero idle bits -> two rx_valid pulses exactly 9*8 cycles apart, rx_data=7'h33 then 7'h7F.
3. Drive rx low for 2 cycles only (glitch) -> FSM returns START->IDLE, no rx_valid, no frame_error, rx_data unchanged.
4. Send 7'h2A with stop bit 0, then hold rx low for 20 bit times -> single frame_error pulse, no rx_valid, debug_state_out=4 until rx goes high, rx_data keeps its previous value.
5. Assert rst for 1 cycle mid-DATA (bit_idx=3) -> next cycle all outputs at reset values; a subsequent clean frame 7'h01 is received correctly.
6. Deassert ena in the middle of DATA -> abort to WAIT_IDLE, no strobes. With ena=0 in IDLE and a full frame sent -> nothing received. With ena=1 and frame 7'h40 -> rx_data=7'h40.
